// File: rtl/debounce_pkg.sv
// Shared types and limits for the debounce_edge input-conditioning stage.
package debounce_pkg;

  typedef enum logic {STABLE, WAIT} db_state_t;

  localparam int DB_MIN_STABLE = 2;

endpackage

// File: rtl/debounce_edge_sync2.sv
// Two-flop synchroniser that brings an asynchronous input into the clk domain.
module sync2 (
  input  logic clk,
  input  logic r,
  input  logic d,
  output logic q
);

  logic s1;

  // NOTE: sequential state uses non-blocking assignments so both flops sample pre-edge values.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/debounce_edge.sv
// Debouncer: synchronises a bouncing input, qualifies changes over STABLE_CYCLES
// enabled samples, and emits a clean level plus single-cycle rise/fall pulses.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic r,
  input  logic d_raw,
  input  logic e,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  if (STABLE_CYCLES < DB_MIN_STABLE) begin : g_bad_stable
    $error("debounce_edge: STABLE_CYCLES must be at least %0d", DB_MIN_STABLE);
  end
  if (CNT_W != $clog2(STABLE_CYCLES)) begin : g_bad_cnt_w
    $error("debounce_edge: CNT_W is derived from STABLE_CYCLES and must not be overridden");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync;
  db_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             level_nx, rise_nx, fall_nx;

  sync2 u_sync2 (
    .clk (clk),
    .r   (r),
    .d   (d_raw),
    .q   (sync)
  );

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state <= STABLE;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      level <= level_nx;
      rise  <= rise_nx;
      fall  <= fall_nx;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    level_nx = level;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    if (e) begin
      unique case (state)
        STABLE: begin
          if (sync != level) begin
            state_nx = WAIT;
            cnt_nx   = CNT_W'(1);
          end else begin
            cnt_nx   = '0;
          end
        end
        WAIT: begin
          if (sync == level) begin
            // Bounce: abandon the candidate and restart qualification later.
            state_nx = STABLE;
            cnt_nx   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nx = STABLE;
            cnt_nx   = '0;
            level_nx = ~level;
            rise_nx  = ~level;
            fall_nx  = level;
          end else begin
            cnt_nx   = cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign busy = (state == WAIT);

endmodule

// File: doc/debounce_edge.md
# debounce_edge

Input-conditioning stage that sits directly upstream of the master-slave `flipflop`. It takes an asynchronous, bouncing raw input, usually a push-button or switch, and synchronises it into the `clk` domain. It then debounces the signal with a consecutive-sample counter and FSM. It produces a clean level plus single-cycle rise/fall pulses, which drive the `d`/`e` pins of the downstream flop.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive enabled samples of a changed input required before `level` toggles. Legal range is ≥ 2.
- `CNT_W`, default `$clog2(STABLE_CYCLES)`: counter width. It is derived and must not be overridden.

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `r`  input  1  reset; asynchronous, active-low. Asserting `r` low resets immediately. Release is synchronous to `clk`.
- `d_raw`  input  1  raw asynchronous input.
- `e`  input  1  sample enable (tick); FSM, counter and `level` advance only when `e`=1.
- `level`  output  1  debounced, registered level.
- `rise`  output  1  one-cycle pulse when `level` goes 0→1.
- `fall`  output  1  one-cycle pulse when `level` goes 1→0.
- `busy`  output  1  high while in WAIT (candidate change being qualified).

## Operation
- **Synchroniser:** two-flop chain `s1`←`d_raw`, `sync`←`s1`. It clocks every cycle regardless of `e`.
- **States:** STABLE and WAIT. Counter `cnt` is `CNT_W` bits.
- **STABLE:**
  - If `e` and `sync`≠`level`, go to WAIT with `cnt`=1.
  - Otherwise hold with `cnt`=0.
- **WAIT, with `e`:**
  - `sync`==`level` (bounce): go to STABLE, `cnt`=0, `level` unchanged, no pulse.
  - `sync`≠`level` and `cnt`==`STABLE_CYCLES`-1: toggle `level`, go to STABLE, `cnt`=0. Assert `rise` for a 0→1 change or `fall` for a 1→0 change, for exactly that one cycle.
  - Otherwise, `cnt`+1.
- **`e`=0:** state, `cnt` and `level` hold. `rise`/`fall` are 0. The synchroniser keeps running.
- **Pulse exclusivity:** `rise` and `fall` are registered and never high together. They are high at most one cycle per toggle, even if `e` stays high.
- **Counter bound:** `cnt` never exceeds `STABLE_CYCLES`-1. There is no wrap-around.

## Timing
- **Reset values:** `s1`=0, `sync`=0, `level`=0, `rise`=0, `fall`=0, `busy`=0, state STABLE, `cnt`=0.
- **Latency, `e`=1 continuously:** `d_raw` changes and is stable before edge 0.
  - `sync` updates at edge 1.
  - The first differing sample is taken at edge 2.
  - `level` and the pulse update at edge `STABLE_CYCLES`+1. The default is edge 5, i.e. visible after the 6th rising edge.
- **With gaps in `e`:** only cycles with `e`=1 count toward qualification. A bounce at any enabled sample restarts qualification from zero.
- **Reset mid-WAIT:** all outputs return to reset values immediately; any pending change is discarded.
- **Input toggling faster than `STABLE_CYCLES`:** `level` never changes and `busy` oscillates.
- **`d_raw` returning to `level` between samples:** this is invisible to the block; only sampled values matter.

## Structure
- **Package `debounce_pkg`:** `typedef enum logic {STABLE, WAIT} db_state_t;` and a `DB_MIN_STABLE` = 2 constant, used by a parameter assertion.
- **Sub-module `sync2`:** two-flop synchroniser with ports `clk`, `r`, `d`, `q`. It resets to 0 and is instantiated once.
- **FSM:** two processes — an asynchronous-reset `always_ff` for state and registers, and an `always_comb` for next-state logic.
- **Assertion:** elaboration-time check that `STABLE_CYCLES` ≥ `DB_MIN_STABLE`.

## Test plan
- **Reset:** hold `r`=0 with `d_raw`=1 for 3 cycles → `level`=`rise`=`fall`=`busy`=0. Release, `e`=1 → `rise`=1 exactly at edge 5 after release, `level`=1 thereafter.
- **Clean fall:** from `level`=1, drive `d_raw`=0 with `e`=1 → `fall` high for one cycle at edge 5, `level`=0. `busy` is high for edges 2–4.
- **Bounce:** `d_raw` pattern 1,1,0,1,1,1,1,1 (one per cycle) from `level`=0 → `level` rises only after 4 consecutive 1 samples post-glitch. No spurious pulse occurs.
- **Enable gating:** `e` high one cycle in three with `d_raw`=1 → `level` rises after the 4th enabled sample. `rise` is high for a single cycle; no pulses occur during `e`=0 cycles.
- **Async reset mid-WAIT:** pull `r` low between clock edges at `cnt`=2 → outputs 0 immediately. After release with `d_raw` still 1, full 4-sample requalification is required.
- **Parameter sweep:** `STABLE_CYCLES`=2 and 7 → `rise` at edges 3 and 8 respectively.
